// File: rtl/unstripe_if.sv
// ============================================================================
// Module   : unstripe_if
// Purpose  : Lane FIFO heads plus downstream byte handshake for unstripe_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface unstripe_if #(
    parameter int DATA_W = 8
);
    logic [3:0]        lane_empty;
    logic [DATA_W-1:0] data_in0;
    logic [DATA_W-1:0] data_in1;
    logic [DATA_W-1:0] data_in2;
    logic [DATA_W-1:0] data_in3;
    logic [3:0]        lane_pop;
    logic              out_ready;
    logic [DATA_W-1:0] data;
    logic              valid;

    // Master owns the lane FIFOs and the downstream consumer.
    modport master (
        output lane_empty, data_in0, data_in1, data_in2, data_in3, out_ready,
        input  lane_pop, data, valid
    );

    modport slave (
        input  lane_empty, data_in0, data_in1, data_in2, data_in3, out_ready,
        output lane_pop, data, valid
    );
endinterface

`default_nettype wire

// File: rtl/unstripe_ctrl.sv
// ============================================================================
// Module   : unstripe_ctrl
// Purpose  : Round-robin merge of 1/2/4 show-ahead lane FIFOs into one byte
//            stream, with lane sync and starvation supervision.
// Revision : 1.0
// ============================================================================
`default_nettype none

module unstripe_ctrl #(
    parameter int DATA_W    = 8,
    parameter int STALL_MAX = 15,
    parameter int CNT_W     = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             enable_i,
    input  wire logic [1:0]       cfg_lanes_i,
    unstripe_if.slave             bus,
    output logic      [1:0]       lane_sel_o,
    output logic      [1:0]       state_o,
    output logic      [CNT_W-1:0] byte_cnt_o,
    output logic                  err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam int         SC_W      = $clog2(STALL_MAX + 1);
    localparam logic [SC_W-1:0] STALL_LIM = SC_W'(STALL_MAX);

    logic [1:0]        state_q,    state_d;
    logic [1:0]        lanes_q,    lanes_d;
    logic [1:0]        lane_sel_q, lane_sel_d;
    logic [SC_W-1:0]   stall_q,    stall_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic              valid_q,    valid_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;

    logic [3:0]        w_mask;
    logic [1:0]        w_sel_max;
    logic [DATA_W-1:0] w_head;
    logic              w_out_free;
    logic              w_go;
    logic              w_stall;

    // lanes_q encoding: 0 = one lane, 1 = two lanes, 2 = four lanes.
    always_comb begin
        w_mask    = 4'b1111;
        w_sel_max = 2'd3;
        case (lanes_q)
            2'd0: begin w_mask = 4'b0001; w_sel_max = 2'd0; end
            2'd1: begin w_mask = 4'b0011; w_sel_max = 2'd1; end
            default: begin w_mask = 4'b1111; w_sel_max = 2'd3; end
        endcase
    end

    always_comb begin
        w_head = bus.data_in0;
        case (lane_sel_q)
            2'd0: w_head = bus.data_in0;
            2'd1: w_head = bus.data_in1;
            2'd2: w_head = bus.data_in2;
            default: w_head = bus.data_in3;
        endcase
    end

    assign w_out_free = !valid_q || bus.out_ready;
    assign w_go       = (state_q == ST_RUN) && enable_i &&
                        !bus.lane_empty[lane_sel_q] && w_out_free;
    // Starvation only counts when the output could have taken a byte.
    assign w_stall    = (state_q == ST_RUN) && enable_i &&
                        bus.lane_empty[lane_sel_q] && w_out_free;

    always_comb begin
        state_d    = state_q;
        lanes_d    = lanes_q;
        lane_sel_d = lane_sel_q;
        stall_d    = stall_q;
        data_d     = data_q;
        valid_d    = valid_q;
        byte_cnt_d = byte_cnt_q;

        if (valid_q && bus.out_ready) begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end

        if (w_go) begin
            data_d  = w_head;
            valid_d = 1'b1;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end

        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_SYNC;
                    lanes_d    = (cfg_lanes_i == 2'd3) ? 2'd2 : cfg_lanes_i;
                    lane_sel_d = 2'd0;
                    stall_d    = '0;
                end
                ST_SYNC: begin
                    if ((bus.lane_empty & w_mask) == 4'b0000) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_go) begin
                        lane_sel_d = (lane_sel_q + 2'd1) & w_sel_max;
                        stall_d    = '0;
                    end else if (w_stall) begin
                        if (stall_q == STALL_LIM) begin
                            state_d = ST_ERR;
                        end else begin
                            stall_d = stall_q + SC_W'(1);
                        end
                    end
                end
                default: state_d = ST_ERR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            lanes_q    <= 2'd0;
            lane_sel_q <= 2'd0;
            stall_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lanes_q    <= lanes_d;
            lane_sel_q <= lane_sel_d;
            stall_q    <= stall_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign bus.lane_pop = w_go ? (4'b0001 << lane_sel_q) : 4'b0000;
    assign bus.data     = data_q;
    assign bus.valid    = valid_q;
    assign lane_sel_o   = lane_sel_q;
    assign state_o      = state_q;
    assign byte_cnt_o   = byte_cnt_q;
    assign err_o        = (state_q == ST_ERR);

endmodule

`default_nettype wire

// File: tb/tb_unstripe_ctrl.sv
// ============================================================================
// Module   : tb_unstripe_ctrl
// Purpose  : Directed self-checking bench for unstripe_ctrl with lane FIFO models.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_unstripe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  cfg_lanes;
    logic [1:0]  lane_sel;
    logic [1:0]  state;
    logic [15:0] byte_cnt;
    logic        err;

    unstripe_if #(.DATA_W(8)) bus ();

    unstripe_ctrl #(.DATA_W(8), .STALL_MAX(15), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_i    (enable),
        .cfg_lanes_i (cfg_lanes),
        .bus         (bus),
        .lane_sel_o  (lane_sel),
        .state_o     (state),
        .byte_cnt_o  (byte_cnt),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    logic [7:0] q0[$], q1[$], q2[$], q3[$];
    logic [7:0] rx[$], exp_q[$];
    logic [3:0] plog[$], exp_p[$];
    logic [3:0] pop_s = 4'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    function automatic void refresh();
        bus.lane_empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
        bus.data_in0   = (q0.size() != 0) ? q0[0] : 8'h00;
        bus.data_in1   = (q1.size() != 0) ? q1[0] : 8'h00;
        bus.data_in2   = (q2.size() != 0) ? q2[0] : 8'h00;
        bus.data_in3   = (q3.size() != 0) ? q3[0] : 8'h00;
    endfunction

    function automatic void clear_lanes();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        rx.delete(); plog.delete();
        refresh();
    endfunction

    // Sample pops and accepted bytes just before each rising edge.
    always @(negedge clk) begin
        #4;
        pop_s = bus.lane_pop;
        if (bus.valid && bus.out_ready) rx.push_back(bus.data);
        if (pop_s != 4'b0) plog.push_back(pop_s);
    end

    always @(posedge clk) begin
        #1;
        if (pop_s[0]) void'(q0.pop_front());
        if (pop_s[1]) void'(q1.pop_front());
        if (pop_s[2]) void'(q2.pop_front());
        if (pop_s[3]) void'(q3.pop_front());
        refresh();
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_streams(input string tag);
        check({tag, "_rx_len"}, rx.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_rx%0d", tag, i), (i < rx.size()) ? {24'h0, rx[i]} : 32'hDEAD, exp_q[i]);
        check({tag, "_pop_len"}, plog.size(), exp_p.size());
        for (int i = 0; i < exp_p.size(); i++)
            check($sformatf("%s_pop%0d", tag, i), (i < plog.size()) ? {28'h0, plog[i]} : 32'hDEAD, exp_p[i]);
    endtask

    task automatic start(input logic [1:0] cfg, input string tag);
        cfg_lanes = cfg;
        enable    = 1'b1;
        @(negedge clk);
        check({tag, "_sync"}, state, 2'd1);
        @(negedge clk);
        check({tag, "_run"}, state, 2'd2);
    endtask

    task automatic stop(input string tag, input logic [15:0] exp_cnt);
        enable = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, state, 2'd0);
        check({tag, "_err_clr"}, err, 1'b0);
        check({tag, "_cnt"}, byte_cnt, exp_cnt);
        clear_lanes();
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; cfg_lanes = 2'd0; bus.out_ready = 1'b1;
        clear_lanes();
        repeat (2) @(negedge clk);
        check("rst_state", state, 2'd0);
        check("rst_valid", bus.valid, 1'b0);
        check("rst_cnt", byte_cnt, 16'd0);
        check("rst_pop", bus.lane_pop, 4'b0);
        check("rst_err", err, 1'b0);
        check("rst_sel", lane_sel, 2'd0);
        reset = 1'b1;
        @(negedge clk);

        // Four lanes, full throughput.
        q0 = {8'hA0, 8'hA1}; q1 = {8'hB0, 8'hB1}; q2 = {8'hC0, 8'hC1}; q3 = {8'hD0, 8'hD1};
        refresh();
        start(2'd2, "s1");
        repeat (10) @(negedge clk);
        exp_q = {8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hA1, 8'hB1, 8'hC1, 8'hD1};
        exp_p = {4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
        check_streams("s1");
        check("s1_cnt", byte_cnt, 16'd8);
        stop("s1", 16'd8);

        // Two lanes; empty lane 2 must not block sync.
        q0 = {8'h11, 8'h33}; q1 = {8'h22, 8'h44};
        refresh();
        start(2'd1, "s2");
        repeat (8) @(negedge clk);
        exp_q = {8'h11, 8'h22, 8'h33, 8'h44};
        exp_p = {4'h1, 4'h2, 4'h1, 4'h2};
        check_streams("s2");
        check("s2_state", state, 2'd2);
        stop("s2", 16'd12);

        // Backpressure mid-stream, then again with lanes drained.
        for (int j = 0; j < 3; j++) begin
            q0.push_back(8'h30 + 8'(4*j)); q1.push_back(8'h31 + 8'(4*j));
            q2.push_back(8'h32 + 8'(4*j)); q3.push_back(8'h33 + 8'(4*j));
        end
        refresh();
        start(2'd2, "s3");
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("s3_frz_data", bus.data, 8'h32);
            check("s3_frz_valid", bus.valid, 1'b1);
            check("s3_frz_pop", bus.lane_pop, 4'b0);
        end
        bus.out_ready = 1'b1;
        repeat (9) @(negedge clk);
        check("s3_last", bus.data, 8'h3B);
        bus.out_ready = 1'b0;
        repeat (20) @(negedge clk);
        check("s3_no_err", state, 2'd2);
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        exp_q = {8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h3A, 8'h3B};
        exp_p = {4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
        check_streams("s3");
        stop("s3", 16'd24);

        // Lane 2 starves: 16 stall cycles reach ERR.
        q0 = {8'h40, 8'h44}; q1 = {8'h41, 8'h45}; q2 = {8'h42}; q3 = {8'h43};
        refresh();
        start(2'd2, "s4");
        repeat (21) @(negedge clk);
        check("s4_pre_err", state, 2'd2);
        @(negedge clk);
        check("s4_err_state", state, 2'd3);
        check("s4_err", err, 1'b1);
        check("s4_err_pop", bus.lane_pop, 4'b0);
        stop("s4", 16'd30);

        // Lane 1 starves briefly, then refills.
        q0 = {8'h51, 8'h53}; q1 = {8'h52};
        refresh();
        start(2'd1, "s5");
        repeat (8) @(negedge clk);
        q0.push_back(8'h55); q1.push_back(8'h54); q1.push_back(8'h56);
        refresh();
        repeat (6) @(negedge clk);
        exp_q = {8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56};
        exp_p = {4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2};
        check_streams("s5");
        check("s5_state", state, 2'd2);
        check("s5_err", err, 1'b0);
        stop("s5", 16'd36);

        // Reset while a byte is pending.
        q0 = {8'h61}; q1 = {8'h62}; q2 = {8'h63}; q3 = {8'h64};
        refresh();
        bus.out_ready = 1'b0;
        start(2'd2, "s6");
        @(negedge clk);
        check("s6_pend_valid", bus.valid, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("s6_valid", bus.valid, 1'b0);
        check("s6_cnt", byte_cnt, 16'd0);
        check("s6_state", state, 2'd0);
        check("s6_pop", bus.lane_pop, 4'b0);
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/unstripe_ctrl.md
Name: unstripe_ctrl

Overview:
Receive-side lane scheduler for the 4-lane byte un-striping path. Pops bytes round-robin from up to four show-ahead lane FIFOs (lane 0 first), merges them into one ordered byte stream with a valid/ready handshake, and supervises lane alignment and starvation. Sits between the per-lane RX FIFOs and the downstream byte consumer; lane count is configurable at run time.

Parameters:
DATA_W, 8, byte width per lane and output
STALL_MAX, 15, consecutive stall cycles on the selected lane before entering ERR
CNT_W, 16, width of the delivered-byte counter

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous reset, active-low
enable  in  1  block enable; low forces return to IDLE
cfg_lanes  in  2  active lanes: 0=1 lane, 1=2 lanes, 2=4 lanes, 3=reserved, treated as 4
lane_empty  in  4  per-lane FIFO empty flag, bit i = lane i
data_in0..data_in3  in  DATA_W each  head-of-FIFO byte for lanes 0..3, valid while lane non-empty
out_ready  in  1  downstream accepts data_out this cycle
lane_pop  out  4  one-hot pop strobe to lane FIFOs, combinational
data  out  DATA_W  merged output byte, registered
valid  out  1  data holds a byte, registered
lane_sel  out  2  lane currently scheduled
state  out  2  0=IDLE, 1=SYNC, 2=RUN, 3=ERR
byte_cnt  out  CNT_W  bytes transferred (valid & out_ready), wraps at 2^CNT_W
err  out  1  high while in ERR

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, lane_sel=0, data=0, valid=0, byte_cnt=0, err=0, stall counter=0, latched lane count=1. lane_pop=0 whenever state!=RUN. Reset mid-transfer discards the output register byte without handshake.
- Active lane count N latched from cfg_lanes only on IDLE->SYNC; changes at other times are ignored.
- IDLE: enable=1 -> SYNC (latch N, lane_sel=0).
- SYNC: waits until lane_empty[N-1:0]==0 (all active lanes hold data) -> RUN. No pops in SYNC. Inactive lanes are never popped and their empty flags are ignored.
- RUN: go = !lane_empty[lane_sel] & (!valid | out_ready). lane_pop[lane_sel]=go. On go: next cycle data=data_in[lane_sel], valid=1, lane_sel=(lane_sel+1) mod N, stall counter=0. Latency: pop at cycle t -> valid at t+1.
- Handshake: valid held with data stable until out_ready=1; pop of the next byte in the same cycle as acceptance is allowed (full throughput 1 byte/cycle). If out_ready=1 and no go, valid clears next cycle.
- Stall: in RUN, selected lane empty and output register free/accepting -> stall counter increments; downstream backpressure alone does not count. Counter reaching STALL_MAX -> ERR next cycle. Counter saturates, clears on any pop.
- ERR: err=1, no pops, pending output byte still drains via handshake. Sticky until enable=0.
- enable=0 in any state -> IDLE next cycle; no pop that cycle; pending valid byte still drains; byte_cnt held (cleared only by reset).
- byte_cnt increments on every cycle with valid & out_ready, in any state; wraps to 0.
- Simultaneous enable=0 and stall threshold: IDLE wins.

Test Plan:
- Reset then enable=1, cfg_lanes=2, lanes 0..3 preloaded with A0/B0/C0/D0, A1/B1/C1/D1, out_ready=1 -> SYNC 1 cycle, then data=A0,B0,C0,D0,A1,B1,C1,D1 on consecutive cycles, byte_cnt=8, lane_pop one-hot 1,2,4,8 repeating.
- cfg_lanes=1, lanes 0/1 loaded 0x11,0x22,0x33,0x44 -> order 0x11,0x22,0x33,0x44; lane_pop[3:2] never asserted; lane 2 empty does not block SYNC.
- Mid-stream out_ready=0 for 3 cycles -> data/valid frozen, lane_pop=0, no stall count; out_ready=1 resumes with no byte lost or duplicated.
- Lane 2 empty for 16 cycles with STALL_MAX=15 in RUN -> state=3, err=1; then enable=0 -> IDLE, err=0, byte_cnt unchanged.
- Lane 1 empty for 5 cycles, then filled -> stall, then order preserved, no ERR.
- reset=0 asserted while valid=1 -> next edge valid=0, byte_cnt=0, state=IDLE, lane_pop=0.
